reg_file_mp: RTL and testbench

- Parametrised successor to the CPU's 8x16 register file.
- Generic width, depth and read-port count, plus two write ports with a fixed collision priority.
- Synchronous reset, a flags register, and a per-register busy scoreboard for the pipelined datapath.
- Sits between decode (read/reserve) and writeback (two retire lanes, e.g. ALU + load).

---
 rtl/cbox_cpu_pkg.sv | 11 +
 rtl/reg_file_scoreboard.sv | 54 +++++
 rtl/reg_file_mp.sv | 95 +++++++++
 tb/tb_reg_file_mp.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbox_cpu_pkg.sv
// Shared CPU constants and types for the register file slice.
package cbox_cpu_pkg;

  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_ZERO   = 0;

  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: writes clear, reserves set (reserve wins),
// register 0 is never busy. Optional macro REG_FILE_BYPASS_EN makes the
// read-out show the post-edge busy value.
module reg_file_scoreboard
  import cbox_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        ws0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        ws1,
  input  logic [NUM_RD*ADDR_W-1:0] rs,
  output logic [NUM_RD-1:0]        busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: retire clears first, then a newer reserve sets.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[ws0] = 1'b0;
    if (we1) busy_d[ws1] = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy register with synchronous reset dropping all reservations.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Per-port busy read-out.
  always_comb begin
    busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
`ifdef REG_FILE_BYPASS_EN
      busy[k] = rst ? busy_q[rs[k*ADDR_W +: ADDR_W]] : busy_d[rs[k*ADDR_W +: ADDR_W]];
`else
      busy[k] = busy_q[rs[k*ADDR_W +: ADDR_W]];
`endif
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write
// lanes (lane 1 wins on collision), flags register and busy scoreboard.
// Optional macro REG_FILE_BYPASS_EN enables write-to-read forwarding.
module reg_file_mp
  import cbox_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned FLAG_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] RS,
  output logic [NUM_RD*DATA_W-1:0] OUT,
  output logic [NUM_RD-1:0]        BUSY,
  input  logic [ADDR_W-1:0]        WS0,
  input  logic                     WE0,
  input  logic [DATA_W-1:0]        IN0,
  input  logic [ADDR_W-1:0]        WS1,
  input  logic                     WE1,
  input  logic [DATA_W-1:0]        IN1,
  input  logic                     RSV_EN,
  input  logic [ADDR_W-1:0]        RSV_ADDR,
  input  logic [FLAG_W-1:0]        FL_IN,
  input  logic                     FL_EN,
  output logic [FLAG_W-1:0]        FL_OUT
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [FLAG_W-1:0] flags_q;

  // Write lanes; lane 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (WE0 && (WS0 != ZERO_ADDR)) regs[WS0] <= IN0;
      if (WE1 && (WS1 != ZERO_ADDR)) regs[WS1] <= IN1;
    end
  end

  // Flags register, independent of the data writes.
  always_ff @(posedge clk) begin
    if (rst)        flags_q <= '0;
    else if (FL_EN) flags_q <= FL_IN;
  end

  // Read muxes; register 0 reads as zero regardless of storage.
  always_comb begin
    OUT = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (RS[k*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
        OUT[k*DATA_W +: DATA_W] = regs[RS[k*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_BYPASS_EN
        if (!rst) begin
          if (WE1 && (WS1 == RS[k*ADDR_W +: ADDR_W]))
            OUT[k*DATA_W +: DATA_W] = IN1;
          else if (WE0 && (WS0 == RS[k*ADDR_W +: ADDR_W]))
            OUT[k*DATA_W +: DATA_W] = IN0;
        end
`endif
      end
    end
  end

  // Flags read-out, forwarded from the load data when bypass is built in.
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    FL_OUT = (!rst && FL_EN) ? FL_IN : flags_q;
`else
    FL_OUT = flags_q;
`endif
  end

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (RSV_EN),
    .rsv_addr (RSV_ADDR),
    .we0      (WE0),
    .ws0      (WS0),
    .we1      (WE1),
    .ws1      (WS1),
    .rs       (RS),
    .busy     (BUSY)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp at NUM_RD=2 and NUM_RD=4 driven in parallel,
// checked against an array model every negedge plus literal expectations.
module tb_reg_file_mp;
  import cbox_cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  rs2;
  logic [11:0] rs4;
  logic [31:0] out2;
  logic [63:0] out4;
  logic [1:0]  busy2;
  logic [3:0]  busy4;
  reg_addr_t   ws0, ws1, rsv_addr;
  logic        we0, we1, rsv_en, fl_en;
  reg_data_t   in0, in1;
  logic [15:0] fl_in, fl2, fl4;

  int errors = 0;
  int checks = 0;

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .FLAG_W(16)) dut2 (
    .clk(clk), .rst(rst), .RS(rs2), .OUT(out2), .BUSY(busy2),
    .WS0(ws0), .WE0(we0), .IN0(in0), .WS1(ws1), .WE1(we1), .IN1(in1),
    .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr), .FL_IN(fl_in), .FL_EN(fl_en), .FL_OUT(fl2)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .FLAG_W(16)) dut4 (
    .clk(clk), .rst(rst), .RS(rs4), .OUT(out4), .BUSY(busy4),
    .WS0(ws0), .WE0(we0), .IN0(in0), .WS1(ws1), .WE1(we1), .IN1(in1),
    .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr), .FL_IN(fl_in), .FL_EN(fl_en), .FL_OUT(fl4)
  );

  // Architectural model: register contents, busy bits, flags.
  logic [15:0] m_regs [8];
  logic        m_busy [8];
  logic [15:0] m_flags;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] <= 16'h0;
        m_busy[i] <= 1'b0;
      end
      m_flags     <= 16'h0;
      model_valid <= 1'b1;
    end else begin
      if (we0 && ws0 != 3'd0) m_regs[ws0] <= in0;
      if (we1 && ws1 != 3'd0) m_regs[ws1] <= in1;
      if (we0) m_busy[ws0] <= 1'b0;
      if (we1) m_busy[ws1] <= 1'b0;
      if (rsv_en && rsv_addr != 3'd0) m_busy[rsv_addr] <= 1'b1;
      if (fl_en) m_flags <= fl_in;
    end
  end

  function automatic logic [15:0] exp_out(logic [2:0] a);
    logic [15:0] d;
    if (a == 3'd0) return 16'h0;
    d = m_regs[a];
`ifdef REG_FILE_BYPASS_EN
    if (!rst) begin
      if (we1 && ws1 == a)      d = in1;
      else if (we0 && ws0 == a) d = in0;
    end
`endif
    return d;
  endfunction

  function automatic logic exp_busy(logic [2:0] a);
    logic b;
    if (a == 3'd0) return 1'b0;
    b = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
    if (!rst) begin
      if ((we0 && ws0 == a) || (we1 && ws1 == a)) b = 1'b0;
      if (rsv_en && rsv_addr == a) b = 1'b1;
    end
`endif
    return b;
  endfunction

  function automatic logic [15:0] exp_fl();
`ifdef REG_FILE_BYPASS_EN
    if (!rst && fl_en) return fl_in;
`endif
    return m_flags;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs of both instances against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk("out2",  {16'h0, out2[k*16 +: 16]}, {16'h0, exp_out(rs2[k*3 +: 3])});
        chk("busy2", {31'h0, busy2[k]},         {31'h0, exp_busy(rs2[k*3 +: 3])});
      end
      for (int k = 0; k < 4; k++) begin
        chk("out4",  {16'h0, out4[k*16 +: 16]}, {16'h0, exp_out(rs4[k*3 +: 3])});
        chk("busy4", {31'h0, busy4[k]},         {31'h0, exp_busy(rs4[k*3 +: 3])});
      end
      chk("fl2", {16'h0, fl2}, {16'h0, exp_fl()});
      chk("fl4", {16'h0, fl4}, {16'h0, exp_fl()});
    end
  end

  task automatic set_rd(input logic [2:0] a);
    logic [2:0] a1, a2, a3;
    a1 = a + 3'd1;
    a2 = a + 3'd2;
    a3 = a + 3'd3;
    rs2 = {a1, a};
    rs4 = {a3, a2, a1, a};
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0; fl_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal checks on read port 0 of both instances.
  task automatic lit_out(input string name, input logic [15:0] e);
    chk({name, "_p2"}, {16'h0, out2[15:0]}, {16'h0, e});
    chk({name, "_p4"}, {16'h0, out4[15:0]}, {16'h0, e});
  endtask

  task automatic lit_busy(input string name, input logic e);
    chk({name, "_p2"}, {31'h0, busy2[0]}, {31'h0, e});
    chk({name, "_p4"}, {31'h0, busy4[0]}, {31'h0, e});
  endtask

  task automatic lit_fl(input string name, input logic [15:0] e);
    chk({name, "_2"}, {16'h0, fl2}, {16'h0, e});
    chk({name, "_4"}, {16'h0, fl4}, {16'h0, e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0; fl_en = 1'b0;
    ws0 = 3'd0; ws1 = 3'd0; rsv_addr = 3'd0;
    in0 = 16'h0; in1 = 16'h0; fl_in = 16'h0;
    set_rd(3'd0);
    tick();
    idle();

    // Reset: r1 written, then reset while writing r2, reserving, loading flags.
    we0 = 1'b1; ws0 = 3'd1; in0 = 16'h1234;
    tick(); idle();
    set_rd(3'd1); #1; lit_out("r1_written", 16'h1234);
    rst = 1'b1; we0 = 1'b1; ws0 = 3'd2; in0 = 16'hBEEF;
    rsv_en = 1'b1; rsv_addr = 3'd3; fl_en = 1'b1; fl_in = 16'h0055;
    tick(); idle();
    set_rd(3'd1); #1; lit_out("rst_r1", 16'h0000);
    set_rd(3'd2); #1; lit_out("rst_r2", 16'h0000);
    set_rd(3'd3); #1; lit_busy("rst_busy_r3", 1'b0);
    lit_fl("rst_fl", 16'h0000);

    // R0 guard.
    set_rd(3'd0);
    we0 = 1'b1; ws0 = 3'd0; in0 = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd0;
    @(negedge clk); #1;
    lit_out("r0_pre", 16'h0000);
    lit_busy("r0_busy_pre", 1'b0);
    tick(); idle();
    lit_out("r0_post", 16'h0000);
    lit_busy("r0_busy_post", 1'b0);

    // Collision: lane 1 wins; distinct lanes both commit.
    we0 = 1'b1; ws0 = 3'd3; in0 = 16'hDEAD; we1 = 1'b1; ws1 = 3'd3; in1 = 16'hBEEF;
    tick(); idle();
    set_rd(3'd3); #1; lit_out("collide_r3", 16'hBEEF);
    we0 = 1'b1; ws0 = 3'd4; in0 = 16'hAAAA; we1 = 1'b1; ws1 = 3'd5; in1 = 16'h5555;
    tick(); idle();
    set_rd(3'd4); #1; lit_out("lane0_r4", 16'hAAAA);
    set_rd(3'd5); #1; lit_out("lane1_r5", 16'h5555);

    // Scoreboard.
    rsv_en = 1'b1; rsv_addr = 3'd2;
    tick(); idle();
    set_rd(3'd2); #1; lit_busy("rsv_r2", 1'b1);
    rsv_en = 1'b1; rsv_addr = 3'd2;
    tick(); idle();
    #1; lit_busy("rsv_again_r2", 1'b1);
    we0 = 1'b1; ws0 = 3'd2; in0 = 16'hABCD;
    tick(); idle();
    #1; lit_busy("wr_clr_r2", 1'b0);
    lit_out("wr_r2", 16'hABCD);
    rsv_en = 1'b1; rsv_addr = 3'd6; we1 = 1'b1; ws1 = 3'd6; in1 = 16'h1357;
    tick(); idle();
    set_rd(3'd6); #1; lit_busy("rsv_wins_r6", 1'b1);
    lit_out("rsv_wr_r6", 16'h1357);

    // Flags load and hold.
    fl_en = 1'b1; fl_in = 16'h00F0;
    tick(); idle();
    lit_fl("fl_load", 16'h00F0);
    fl_en = 1'b0; fl_in = 16'hFFFF;
    tick(); idle();
    lit_fl("fl_hold", 16'h00F0);

    // Forwarding behaviour before the edge, stored values after it.
    set_rd(3'd1);
    we1 = 1'b1; ws1 = 3'd1; in1 = 16'hBADE;
    @(negedge clk); #1;
`ifdef REG_FILE_BYPASS_EN
    lit_out("byp_pre_r1", 16'hBADE);
`else
    lit_out("byp_pre_r1", 16'h0000);
`endif
    tick(); idle();
    lit_out("byp_post_r1", 16'hBADE);
    set_rd(3'd7);
    rsv_en = 1'b1; rsv_addr = 3'd7; fl_en = 1'b1; fl_in = 16'h0A0A;
    @(negedge clk); #1;
`ifdef REG_FILE_BYPASS_EN
    lit_busy("byp_pre_busy_r7", 1'b1);
    lit_fl("byp_pre_fl", 16'h0A0A);
`else
    lit_busy("byp_pre_busy_r7", 1'b0);
    lit_fl("byp_pre_fl", 16'h00F0);
`endif
    tick(); idle();
    lit_busy("byp_post_busy_r7", 1'b1);
    lit_fl("byp_post_fl", 16'h0A0A);

    // Reset mid-operation drops reservations and data.
    rst = 1'b1; we0 = 1'b1; ws0 = 3'd6; in0 = 16'h7777;
    tick(); idle();
    set_rd(3'd6); #1; lit_busy("rst_drop_r6", 1'b0);
    lit_out("rst_clr_r6", 16'h0000);
    set_rd(3'd7); #1; lit_busy("rst_drop_r7", 1'b0);

    // Mixed traffic; the per-cycle compare process checks every output.
    for (int n = 0; n < 48; n++) begin
      rst      = ($urandom_range(0, 15) == 0);
      we0      = 1'($urandom);
      ws0      = 3'($urandom);
      in0      = 16'($urandom);
      we1      = 1'($urandom);
      ws1      = (n % 5 == 0) ? ws0 : 3'($urandom);
      in1      = 16'($urandom);
      rsv_en   = 1'($urandom);
      rsv_addr = (n % 3 == 0) ? ws1 : 3'($urandom);
      fl_en    = 1'($urandom);
      fl_in    = 16'($urandom);
      set_rd((n % 4 == 0) ? ws1 : 3'($urandom));
      tick();
    end
    idle();
    tick();
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
